// File: rtl/pipelined_barrel_shifter_if.sv
// Operand/result bus of the pipelined barrel shifter: a valid/ready operation channel
// in and a valid/ready result channel out.
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH = 32
) ();
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_amount;
  logic [1:0]         in_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_amount, in_op, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_amount, in_op, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Elastic pipelined barrel shifter (SLL/SRL/SRA/ROR). The shift amount is split into
// power-of-two layers, LAYERS_PER_STAGE of them per registered stage.
module pipelined_barrel_shifter #(
  parameter int WIDTH            = 32,
  parameter int LAYERS_PER_STAGE = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  pipelined_barrel_shifter_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int STAGES  = (SHAMT_W + LAYERS_PER_STAGE - 1) / LAYERS_PER_STAGE;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] amount;
    shift_op_e          op;
    logic               sign;   // MSB of the original operand, used as SRA fill
  } stage_t;

  stage_t            stage_q [STAGES];
  stage_t            stage_d [STAGES];
  stage_t            src     [STAGES];
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] load;
  logic              all_full;

  function automatic logic [WIDTH-1:0] shift_layer(
    input logic [WIDTH-1:0] d,
    input int               sh,
    input shift_op_e        op,
    input logic             sign
  );
    logic [WIDTH-1:0] r;
    case (op)
      OP_SLL:  r = d << sh;
      OP_SRL:  r = d >> sh;
      OP_SRA:  r = (d >> sh) | ({WIDTH{sign}} << (WIDTH - sh));
      default: r = (d >> sh) | (d << (WIDTH - sh));
    endcase
    return r;
  endfunction

  // NOTE: every variable gets a value before any conditional use, so no latches are inferred.
  always_comb begin
    src_valid[0]  = bus.in_valid;
    src[0].data   = bus.in_data;
    src[0].amount = bus.in_amount;
    src[0].op     = shift_op_e'(bus.in_op);
    src[0].sign   = bus.in_data[WIDTH-1];
    for (int k = 1; k < STAGES; k++) begin
      src[k]       = stage_q[k-1];
      src_valid[k] = valid_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      stage_d[k] = src[k];
      for (int l = 0; l < LAYERS_PER_STAGE; l++) begin
        if (((k * LAYERS_PER_STAGE + l) < SHAMT_W) &&
            src[k].amount[(k * LAYERS_PER_STAGE + l) % SHAMT_W]) begin
          stage_d[k].data = shift_layer(stage_d[k].data, 1 << (k * LAYERS_PER_STAGE + l),
                                        src[k].op, src[k].sign);
        end
      end
    end

    // A stage can load while the output drains or any stage at or below it is empty,
    // which lets bubbles collapse under backpressure.
    all_full = 1'b1;
    for (int k = STAGES - 1; k >= 0; k--) begin
      all_full   = all_full & valid_q[k];
      load[k]    = bus.out_ready | !all_full;
      valid_d[k] = flush ? 1'b0 : (load[k] ? src_valid[k] : valid_q[k]);
    end
  end

  // NOTE: state updates use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      // NOTE: payload registers are reset as well so out_data reads 0 straight out of reset.
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) begin
        if (load[k] && src_valid[k]) begin
          stage_q[k] <= stage_d[k];
        end
      end
    end
  end

  assign bus.in_ready  = load[0] | flush;
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.out_data  = stage_q[STAGES-1].data;
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter: directed vectors, backpressure, flush,
// async reset and random streams at three width/layer configurations.
module tb_pipelined_barrel_shifter;
  logic clk = 1'b0;
  logic reset_n;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] stim_data [$];
  int          stim_amt  [$];
  logic [1:0]  stim_op   [$];

  always #5 clk = ~clk;

  pipelined_barrel_shifter_if #(.WIDTH(32)) b32 ();
  pipelined_barrel_shifter_if #(.WIDTH(16)) b16 ();
  pipelined_barrel_shifter_if #(.WIDTH(64)) b64 ();

  pipelined_barrel_shifter #(.WIDTH(32), .LAYERS_PER_STAGE(2)) dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(b32.slave));
  pipelined_barrel_shifter #(.WIDTH(16), .LAYERS_PER_STAGE(1)) dut16 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(b16.slave));
  pipelined_barrel_shifter #(.WIDTH(64), .LAYERS_PER_STAGE(3)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(b64.slave));

  function automatic int width_of(input int sel);
    return (sel == 0) ? 32 : (sel == 1) ? 16 : 64;
  endfunction

  // Reference: each result bit taken straight from the operand definition of the op.
  function automatic logic [63:0] ref_shift(input logic [63:0] d, input int a,
                                            input logic [1:0] op, input int w);
    logic [63:0] mask;
    logic [63:0] r;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    d    = d & mask;
    r    = '0;
    for (int i = 0; i < w; i++) begin
      case (op)
        2'b00:   r[i] = (i >= a) ? d[i-a] : 1'b0;
        2'b01:   r[i] = (i + a < w) ? d[i+a] : 1'b0;
        2'b10:   r[i] = (i + a < w) ? d[i+a] : d[w-1];
        default: r[i] = d[(i+a)%w];
      endcase
    end
    return r;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [63:0] d, input int a,
                       input logic [1:0] op, input logic ordy);
    case (sel)
      0: begin
        b32.in_valid = v; b32.in_data = d[31:0]; b32.in_amount = a[4:0];
        b32.in_op = op; b32.out_ready = ordy;
      end
      1: begin
        b16.in_valid = v; b16.in_data = d[15:0]; b16.in_amount = a[3:0];
        b16.in_op = op; b16.out_ready = ordy;
      end
      default: begin
        b64.in_valid = v; b64.in_data = d; b64.in_amount = a[5:0];
        b64.in_op = op; b64.out_ready = ordy;
      end
    endcase
  endtask

  task automatic sample(input int sel, output logic ir, output logic ov, output logic [63:0] od);
    case (sel)
      0: begin ir = b32.in_ready; ov = b32.out_valid; od = {32'd0, b32.out_data}; end
      1: begin ir = b16.in_ready; ov = b16.out_valid; od = {48'd0, b16.out_data}; end
      default: begin ir = b64.in_ready; ov = b64.out_valid; od = b64.out_data; end
    endcase
  endtask

  task automatic idle_all();
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 64'd0, 0, 2'b00, 1'b1);
  endtask

  // One op on the 32-bit instance; checks result and STAGES-cycle latency.
  task automatic single_op(input string name, input logic [31:0] d, input int a,
                           input logic [1:0] op, input logic [31:0] exp);
    logic ir, ov;
    logic [63:0] od;
    int lat;
    drive(0, 1'b1, {32'd0, d}, a, op, 1'b1);
    @(negedge clk); sample(0, ir, ov, od);
    checks++;
    if (ir !== 1'b1) begin
      errors++; $display("FAIL %s_in_ready: got %b expected 1", name, ir);
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 64'd0, 0, 2'b00, 1'b1);
    lat = 1;
    @(negedge clk); sample(0, ir, ov, od);
    while (ov !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
      @(negedge clk); sample(0, ir, ov, od);
    end
    checks++;
    if (ov !== 1'b1 || od[31:0] !== exp || lat != 3) begin
      errors++;
      $display("FAIL %s: got data %h latency %0d valid %b expected data %h latency 3",
               name, od[31:0], lat, ov, exp);
    end
    @(posedge clk); #1;
  endtask

  // Streams the stim queues through one instance. mode 0: always ready, 1: random
  // valid/ready, 2: ready held low for 5 cycles mid-stream.
  task automatic run_ops(input int sel, input int mode, input string name);
    logic [63:0] exp_q [$];
    logic [63:0] od, hold_d, exp;
    logic ir, ov, v, r, hold, keep, saw_full;
    int issued, got, cyc, n, w;
    w = width_of(sel); n = stim_data.size();
    issued = 0; got = 0; cyc = 0; hold = 1'b0; keep = 1'b0; saw_full = 1'b0; hold_d = '0;
    while (got < n && cyc < 3000) begin
      v = (issued < n) && (keep || mode != 1 || $urandom_range(0, 3) != 0);
      case (mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 2) != 0);
        default: r = !(cyc >= 4 && cyc < 9);
      endcase
      drive(sel, v, v ? stim_data[issued] : 64'd0, v ? stim_amt[issued] : 0,
            v ? stim_op[issued] : 2'b00, r);
      @(negedge clk); sample(sel, ir, ov, od);
      if (hold) begin
        checks++;
        if (ov !== 1'b1 || od !== hold_d) begin
          errors++; $display("FAIL %s_stall_hold: got valid %b data %h expected 1 %h",
                             name, ov, od, hold_d);
        end
      end
      if (ov === 1'b1 && r) begin
        checks++; got++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s_unexpected: got %h expected no result", name, od);
        end else begin
          exp = exp_q.pop_front();
          if (od !== exp) begin
            errors++; $display("FAIL %s_result%0d: got %h expected %h", name, got, od, exp);
          end
        end
      end
      if (v && ir === 1'b1) begin
        exp_q.push_back(ref_shift(stim_data[issued], stim_amt[issued], stim_op[issued], w));
        issued++;
      end
      if (v && ir === 1'b0) saw_full = 1'b1;
      keep   = v && ir !== 1'b1;
      hold   = (ov === 1'b1) && !r;
      hold_d = od;
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (got != n) begin
      errors++; $display("FAIL %s_timeout: got %0d results expected %0d", name, got, n);
    end
    if (mode == 2) begin
      checks++;
      if (!saw_full) begin
        errors++; $display("FAIL %s_in_ready_drop: got in_ready never 0 expected 0 when full", name);
      end
    end
    drive(sel, 1'b0, 64'd0, 0, 2'b00, 1'b1);
    stim_data.delete(); stim_amt.delete(); stim_op.delete();
  endtask

  task automatic fill_random(input int w, input int n);
    int a;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 4))
        0:       a = 0;
        1:       a = w - 1;
        default: a = $urandom_range(0, w - 1);
      endcase
      stim_data.push_back({$urandom, $urandom});
      stim_amt.push_back(a);
      stim_op.push_back(2'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset();
    logic ir, ov;
    logic [63:0] od;
    reset_n = 1'b0; flush = 1'b0;
    idle_all();
    #1;
    for (int s = 0; s < 3; s++) begin
      sample(s, ir, ov, od);
      checks++;
      if (ov !== 1'b0 || od !== 64'd0 || ir !== 1'b1) begin
        errors++; $display("FAIL reset_state%0d: got valid %b data %h ready %b expected 0 0 1",
                           s, ov, od, ir);
      end
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_directed();
    single_op("sll_1_by_31",   32'h0000_0001, 31, 2'b00, 32'h8000_0000);
    single_op("srl_by_4",      32'h8000_0000,  4, 2'b01, 32'h0800_0000);
    single_op("sra_neg_by_4",  32'h8000_00F0,  4, 2'b10, 32'hF800_000F);
    single_op("sra_pos_by_31", 32'h7FFF_FFFF, 31, 2'b10, 32'h0000_0000);
    single_op("sra_neg_by_31", 32'h8000_0000, 31, 2'b10, 32'hFFFF_FFFF);
    single_op("ror_by_8",      32'h1234_5678,  8, 2'b11, 32'h7812_3456);
    single_op("ror_by_31",     32'h0000_0001, 31, 2'b11, 32'h0000_0002);
    single_op("sll_by_16",     32'hFFFF_FFFF, 16, 2'b00, 32'hFFFF_0000);
    for (int op = 0; op < 4; op++) begin
      single_op($sformatf("amount0_op%0d", op), 32'hDEAD_BEEF, 0, 2'(op), 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_back_to_back();
    fill_random(32, 8);
    run_ops(0, 2, "back_to_back");
  endtask

  task automatic test_flush();
    logic ir, ov;
    logic [63:0] od;
    int seen;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 64'h1111_0000 + 64'(i), i + 1, 2'b00, 1'b1);
      flush = (i == 2);
      @(negedge clk); sample(0, ir, ov, od);
      if (i == 2) begin
        checks++;
        if (ir !== 1'b1) begin
          errors++; $display("FAIL flush_in_ready: got %b expected 1", ir);
        end
      end
      @(posedge clk); #1;
    end
    flush = 1'b0;
    drive(0, 1'b0, 64'd0, 0, 2'b00, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); sample(0, ir, ov, od);
      if (ov === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL flush_no_output: got %0d valid cycles expected 0", seen);
    end
    single_op("flush_recover", 32'h0F0F_0F0F, 4, 2'b11, 32'hF0F0_F0F0);
  endtask

  task automatic test_async_reset();
    logic ir, ov;
    logic [63:0] od;
    drive(0, 1'b1, 64'hA5A5_0F0F, 4, 2'b01, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b1, 64'h0000_00FF, 8, 2'b00, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 64'd0, 0, 2'b00, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    sample(0, ir, ov, od);
    checks++;
    if (ov !== 1'b1 || od[31:0] !== 32'h0A5A_50F0) begin
      errors++; $display("FAIL pre_reset_held: got valid %b data %h expected 1 0a5a50f0", ov, od);
    end
    reset_n = 1'b0;
    #1;
    sample(0, ir, ov, od);
    checks++;
    if (ov !== 1'b0 || od !== 64'd0 || ir !== 1'b1) begin
      errors++; $display("FAIL async_reset: got valid %b data %h ready %b expected 0 0 1", ov, od, ir);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive(0, 1'b0, 64'd0, 0, 2'b00, 1'b1);
    single_op("post_reset", 32'h0000_00FF, 8, 2'b00, 32'h0000_FF00);
  endtask

  task automatic test_random();
    for (int s = 0; s < 3; s++) begin
      fill_random(width_of(s), 80);
      run_ops(s, 1, $sformatf("random_w%0d", width_of(s)));
      for (int op = 0; op < 4; op++) begin
        stim_data.push_back({$urandom, $urandom});
        stim_amt.push_back(0);
        stim_op.push_back(2'(op));
      end
      run_ops(s, 0, $sformatf("amount0_w%0d", width_of(s)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
